seq_alu_core: RTL

- Parametrised, clocked successor of the combinational switch/button ALU datapath.
- Operands and opcode are captured from a shared data bus by button-style strobes. Each strobe passes through its own synchroniser and rising-edge detector.
- Logic/add/shift ops complete in one cycle. Multiply and divide are iterative and take WIDTH cycles.
- A 2*WIDTH result register, status flags, and busy/done handshake sit behind the top-level pin wrapper, which drives switches and buttons into it.

---
 rtl/seq_alu_core.sv | 252 +++++++++++++++++++++++++
 1 files changed

// File: rtl/seq_alu_core.sv
// seq_alu_core: clocked ALU with strobe-captured operands/opcode, single-cycle
// logic/add/shift ops, iterative shift-add multiply and restoring divide.
module seq_alu_core #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             ld_a,
    input  logic             ld_b,
    input  logic             ld_op,
    input  logic             exec,
    input  logic             sel_hi,
    output logic [WIDTH-1:0] result_out,
    output logic [4:0]       flags,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CNT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned NSTB   = 4;
    localparam int unsigned STB_A  = 0;
    localparam int unsigned STB_B  = 1;
    localparam int unsigned STB_OP = 2;
    localparam int unsigned STB_EX = 3;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_SHR = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;
    localparam logic [3:0] OP_DIV = 4'd9;
    localparam logic [3:0] OP_CMP = 4'd10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV
    } state_t;

    // strobe synchronisers, index 0 is the newest sample
    logic [SYNC_STAGES-1:0][NSTB-1:0] sync_q;
    logic [NSTB-1:0]                  prev_q;
    logic [NSTB-1:0]                  pulse;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
    logic [3:0]           op_q, op_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic [4:0]           flags_q, flags_d;
    logic                 busy_q, busy_d, done_q, done_d;
    logic [WIDTH-1:0]     work_hi_q, work_hi_d, work_lo_q, work_lo_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic [WIDTH:0]       sum_full, diff_full;
    logic                 add_ovf, sub_ovf;
    logic [WIDTH-1:0]     alu_lo, alu_hi;
    logic                 alu_c, alu_v, alu_e, alu_use_diff, alu_n, alu_z;

    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       div_shift, div_trial;
    logic [WIDTH-1:0]     div_rem, div_quo;
    logic                 last_iter;

    // synchroniser chain and previous-value flop for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], {exec, ld_op, ld_b, ld_a}};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign pulse = sync_q[SYNC_STAGES-1] & ~prev_q;

    assign sum_full  = {1'b0, a_q} + {1'b0, b_q};
    assign diff_full = {1'b0, a_q} - {1'b0, b_q};
    assign add_ovf   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_full[WIDTH-1] != a_q[WIDTH-1]);
    assign sub_ovf   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff_full[WIDTH-1] != a_q[WIDTH-1]);

    // single-cycle result and flag sources selected by the current opcode
    always_comb begin
        alu_lo       = '0;
        alu_hi       = '0;
        alu_c        = 1'b0;
        alu_v        = 1'b0;
        alu_e        = 1'b0;
        alu_use_diff = 1'b0;
        case (op_q)
            OP_ADD: begin
                alu_lo = sum_full[WIDTH-1:0];
                alu_c  = sum_full[WIDTH];
                alu_v  = add_ovf;
            end
            OP_SUB: begin
                alu_lo = diff_full[WIDTH-1:0];
                alu_c  = diff_full[WIDTH];
                alu_v  = sub_ovf;
            end
            OP_AND: alu_lo = a_q & b_q;
            OP_OR:  alu_lo = a_q | b_q;
            OP_XOR: alu_lo = a_q ^ b_q;
            OP_NOT: alu_lo = ~a_q;
            OP_SHL: begin
                alu_lo = {a_q[WIDTH-2:0], 1'b0};
                alu_c  = a_q[WIDTH-1];
            end
            OP_SHR: begin
                alu_lo = {1'b0, a_q[WIDTH-1:1]};
                alu_c  = a_q[0];
            end
            OP_CMP: begin
                alu_c        = diff_full[WIDTH];
                alu_v        = sub_ovf;
                alu_use_diff = 1'b1;
            end
            OP_DIV: begin
                // only reaches here with B == 0
                alu_lo = '1;
                alu_hi = a_q;
                alu_e  = 1'b1;
            end
            OP_MUL: alu_lo = '0;
            default: alu_e = 1'b1;
        endcase
    end

    assign alu_n = alu_use_diff ? diff_full[WIDTH-1] : alu_lo[WIDTH-1];
    assign alu_z = alu_use_diff ? (diff_full[WIDTH-1:0] == '0) : (alu_lo == '0);

    // one shift-add multiply step and one restoring divide step
    assign mul_sum   = {1'b0, work_hi_q} + (work_lo_q[0] ? {1'b0, a_q} : '0);
    assign mul_next  = {mul_sum, work_lo_q[WIDTH-1:1]};
    assign div_shift = {work_hi_q, work_lo_q[WIDTH-1]};
    assign div_trial = div_shift - {1'b0, b_q};
    assign div_rem   = div_trial[WIDTH] ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0];
    assign div_quo   = {work_lo_q[WIDTH-2:0], ~div_trial[WIDTH]};
    assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

    // next-state and register updates
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        result_d  = result_q;
        flags_d   = flags_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        work_hi_d = work_hi_q;
        work_lo_d = work_lo_q;
        cnt_d     = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (pulse[STB_A])  a_d  = data_in;
                if (pulse[STB_B])  b_d  = data_in;
                if (pulse[STB_OP]) op_d = data_in[3:0];
                if (pulse[STB_EX]) begin
                    if (op_q == OP_MUL) begin
                        state_d   = S_MUL;
                        busy_d    = 1'b1;
                        work_hi_d = '0;
                        work_lo_d = b_q;
                        cnt_d     = '0;
                    end else if ((op_q == OP_DIV) && (b_q != '0)) begin
                        state_d   = S_DIV;
                        busy_d    = 1'b1;
                        work_hi_d = '0;
                        work_lo_d = a_q;
                        cnt_d     = '0;
                    end else begin
                        result_d = {alu_hi, alu_lo};
                        flags_d  = {alu_e, alu_v, alu_c, alu_n, alu_z};
                        done_d   = 1'b1;
                    end
                end
            end
            S_MUL: begin
                work_hi_d = mul_next[2*WIDTH-1:WIDTH];
                work_lo_d = mul_next[WIDTH-1:0];
                cnt_d     = cnt_q + CNT_W'(1);
                if (last_iter) begin
                    result_d = mul_next;
                    flags_d  = {1'b0, 1'b0, (mul_next[2*WIDTH-1:WIDTH] != '0),
                                mul_next[WIDTH-1], (mul_next == '0)};
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            S_DIV: begin
                work_hi_d = div_rem;
                work_lo_d = div_quo;
                cnt_d     = cnt_q + CNT_W'(1);
                if (last_iter) begin
                    result_d = {div_rem, div_quo};
                    flags_d  = {1'b0, 1'b0, 1'b0, div_quo[WIDTH-1], (div_quo == '0)};
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // state and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            result_q  <= '0;
            flags_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            work_hi_q <= '0;
            work_lo_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            result_q  <= result_d;
            flags_q   <= flags_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            work_hi_q <= work_hi_d;
            work_lo_q <= work_lo_d;
            cnt_q     <= cnt_d;
        end
    end

    assign result_out = sel_hi ? result_q[2*WIDTH-1:WIDTH] : result_q[WIDTH-1:0];
    assign flags      = flags_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule
